seg7_scan: RTL

//  Downstream display stage for the hh:mm digit counters. Takes four BCD digits
//  (hours tens/units from the 24 h counter, minutes tens/units from the 60 min counter).

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg7_scan.sv | 104 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment codes for the seg7 display slice.
package seg7_pkg;

    localparam int unsigned NDIGITS = 4;

    typedef logic [3:0] bcd_t;

    // Segment order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner with blinking colon, all outputs registered.
// Define SEG7_LZB_EN to blank a leading zero in the hours-tens digit.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 32,
    parameter int unsigned COLON_DIV = 16384
) (
    input  logic       clk32k_i,
    input  logic       rstn_i,
    input  logic       en_i,
    input  logic [3:0] min0_i,
    input  logic [3:0] min1_i,
    input  logic [3:0] hour0_i,
    input  logic [3:0] hour1_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       colon_o
);

    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned CW = (COLON_DIV > 1) ? $clog2(COLON_DIV) : 1;

    logic [SW-1:0]             scan_cnt_q, scan_cnt_d;
    logic [1:0]                dig_idx_q, dig_idx_d;
    logic [CW-1:0]             blink_cnt_q, blink_cnt_d;
    logic                      colon_q, colon_d;
    logic [NDIGITS-1:0][3:0]   snap_q, snap_d;
    logic [6:0]                seg_q, seg_d;
    logic [3:0]                an_q, an_d;

    logic       scan_last, blink_last, frame_end, lzb;
    logic [6:0] dec_seg;

    assign scan_last  = (scan_cnt_q == SW'(SCAN_DIV - 1));
    assign blink_last = (blink_cnt_q == CW'(COLON_DIV - 1));
    assign frame_end  = scan_last && (dig_idx_q == 2'd3);

    seg7_decode u_dec (
        .bcd_i (snap_q[dig_idx_q]),
        .seg_o (dec_seg)
    );

`ifdef SEG7_LZB_EN
    assign lzb = (dig_idx_q == 2'd3) && (snap_q[3] == 4'd0);
`else
    assign lzb = 1'b0;
`endif

    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        dig_idx_d   = dig_idx_q;
        blink_cnt_d = blink_cnt_q;
        colon_d     = colon_q;
        snap_d      = snap_q;
        seg_d       = SEG_OFF;
        an_d        = '0;
        if (!en_i) begin
            // Disabled: hold everything at frame start but keep the snapshot live
            scan_cnt_d  = '0;
            dig_idx_d   = '0;
            blink_cnt_d = '0;
            colon_d     = 1'b0;
            snap_d      = {hour1_i, hour0_i, min1_i, min0_i};
        end else begin
            scan_cnt_d  = scan_last ? '0 : scan_cnt_q + 1'b1;
            dig_idx_d   = scan_last ? dig_idx_q + 2'd1 : dig_idx_q;
            blink_cnt_d = blink_last ? '0 : blink_cnt_q + 1'b1;
            colon_d     = blink_last ? ~colon_q : colon_q;
            if (frame_end) begin
                snap_d = {hour1_i, hour0_i, min1_i, min0_i};
            end
            if (scan_cnt_q != '0) begin
                an_d  = 4'b0001 << dig_idx_q;
                seg_d = lzb ? SEG_OFF : dec_seg;
            end
        end
    end

    always_ff @(posedge clk32k_i or negedge rstn_i) begin
        if (!rstn_i) begin
            scan_cnt_q  <= '0;
            dig_idx_q   <= '0;
            blink_cnt_q <= '0;
            colon_q     <= 1'b0;
            snap_q      <= '0;
            seg_q       <= '0;
            an_q        <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            dig_idx_q   <= dig_idx_d;
            blink_cnt_q <= blink_cnt_d;
            colon_q     <= colon_d;
            snap_q      <= snap_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign colon_o = colon_q;

endmodule
